// File: rtl/zero_extend.sv
// Immediate-extension unit: combinational zero extension plus a registered,
// mode-selectable extension with a one-cycle valid flag.
module zero_extend #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] ext_q,
  output logic             ext_valid
);

  localparam int unsigned PadW = OUT_W - IN_W;

  if (IN_W < 1) begin : g_bad_in_w
    $error("zero_extend: IN_W must be at least 1");
  end
  if (OUT_W <= IN_W) begin : g_bad_out_w
    $error("zero_extend: OUT_W must be greater than IN_W");
  end

  typedef enum logic [1:0] {
    ModeZero  = 2'b00,
    ModeSign  = 2'b01,
    ModeShl1  = 2'b10,
    ModeUpper = 2'b11
  } ext_mode_e;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] ext_d;
  logic             ext_valid_d;

  assign zext = {{PadW{1'b0}}, in};
  assign out  = zext;

  always_comb begin
    ext_d       = ext_q;
    ext_valid_d = 1'b0;
    if (in_valid) begin
      ext_valid_d = 1'b1;
      unique case (ext_mode_e'(mode))
        ModeZero:  ext_d = zext;
        ModeSign:  ext_d = {{PadW{in[IN_W-1]}}, in};
        // OUT_W > IN_W guarantees the shifted-out MSB of zext is always zero.
        ModeShl1:  ext_d = zext << 1;
        ModeUpper: ext_d = zext << PadW;
        default:   ext_d = zext;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q     <= '0;
      ext_valid <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      ext_valid <= ext_valid_d;
    end
  end

endmodule

// File: tb/tb_zero_extend.sv
// Directed and swept checks of zero_extend: combinational out, registered
// ext_q/ext_valid per mode, hold on invalid cycles and asynchronous reset.
module tb_zero_extend;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in;
  logic        in_valid;
  logic [1:0]  mode;
  logic [15:0] out;
  logic [15:0] ext_q;
  logic        ext_valid;

  int checks_total;
  int checks_failed;

  zero_extend #(
    .IN_W (8),
    .OUT_W(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .in_valid (in_valid),
    .mode     (mode),
    .out      (out),
    .ext_q    (ext_q),
    .ext_valid(ext_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks_total++;
    assert (observed === expected)
    else begin
      checks_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Arithmetic reference, deliberately not written as bit concatenation.
  function automatic logic [15:0] ref_ext(input logic [7:0] v, input logic [1:0] m);
    int unsigned x;
    x = v;
    case (m)
      2'd0:    return 16'(x);
      2'd1:    return (x >= 128) ? 16'(x + 16'hFF00) : 16'(x);
      2'd2:    return 16'(x * 2);
      default: return 16'(x * 256);
    endcase
  endfunction

  // Advance one rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] held;

  initial begin
    checks_total  = 0;
    checks_failed = 0;
    rst_n    = 1'b0;
    in       = 8'h00;
    in_valid = 1'b0;
    mode     = 2'b00;
    #1;
    check("reset_ext_q", ext_q, 16'h0000);
    check("reset_ext_valid", {15'd0, ext_valid}, 16'h0000);

    // Combinational path, including while reset is asserted.
    in = 8'h73; mode = 2'b11;
    #20;
    check("out_73", out, 16'h0073);
    in = 8'hFF; mode = 2'b01;
    #20;
    check("out_ff", out, 16'h00FF);

    tick();
    rst_n = 1'b1;
    check("idle_ext_valid", {15'd0, ext_valid}, 16'h0000);

    in_valid = 1'b1; mode = 2'b01; in = 8'hFF;
    tick();
    check("sign_ff", ext_q, 16'hFFFF);
    check("sign_ff_valid", {15'd0, ext_valid}, 16'h0001);
    in = 8'h73;
    tick();
    check("sign_73", ext_q, 16'h0073);

    mode = 2'b10; in = 8'h80;
    tick();
    check("shl_80", ext_q, 16'h0100);
    check("shl_80_valid", {15'd0, ext_valid}, 16'h0001);
    mode = 2'b11; in = 8'h73;
    tick();
    check("upper_73", ext_q, 16'h7300);
    check("upper_73_valid", {15'd0, ext_valid}, 16'h0001);

    mode = 2'b00; in = 8'h73;
    tick();
    check("zero_73", ext_q, 16'h0073);
    in_valid = 1'b0; in = 8'hA5;
    tick();
    check("hold_valid_low", {15'd0, ext_valid}, 16'h0000);
    check("hold_ext_q", ext_q, 16'h0073);
    check("hold_out_a5", out, 16'h00A5);
    in = 8'h3C;
    tick();
    check("hold_ext_q2", ext_q, 16'h0073);
    check("hold_out_3c", out, 16'h003C);

    // Asynchronous reset between edges.
    in_valid = 1'b1; mode = 2'b11; in = 8'h73;
    tick();
    check("pre_rst_ext_q", ext_q, 16'h7300);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ext_q", ext_q, 16'h0000);
    check("async_rst_valid", {15'd0, ext_valid}, 16'h0000);
    in = 8'h5A;
    #1;
    check("rst_out_5a", out, 16'h005A);
    tick();
    check("rst_held_ext_q", ext_q, 16'h0000);
    check("rst_held_valid", {15'd0, ext_valid}, 16'h0000);
    rst_n = 1'b1; mode = 2'b00; in = 8'h01;
    tick();
    check("post_rst_01", ext_q, 16'h0001);
    check("post_rst_valid", {15'd0, ext_valid}, 16'h0001);

    // Sweep all inputs under every mode with random idle gaps.
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          held = ext_q;
          in_valid = 1'b0;
          in = 8'($urandom);
          tick();
          check("sweep_gap_valid", {15'd0, ext_valid}, 16'h0000);
          check("sweep_gap_hold", ext_q, held);
        end
        in_valid = 1'b1;
        mode = 2'(m);
        in = 8'(i);
        #1;
        check("sweep_out", out, 16'(i));
        tick();
        check("sweep_ext_q", ext_q, ref_ext(8'(i), 2'(m)));
        check("sweep_valid", {15'd0, ext_valid}, 16'h0001);
      end
    end

    $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
    $finish;
  end

endmodule
